// File: rtl/c3lib_scan_shift_ctrl.sv
// rtl/c3lib_scan_shift_ctrl.sv - scan-chain load/unload sequencer; optional CAPTURE cycle via C3LIB_SCAN_CAPTURE_EN
module c3lib_scan_shift_ctrl #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] load_data,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] unload_data,
  output logic                 scan_en,
  output logic                 scan_in,
  input  logic                 scan_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
`ifdef C3LIB_SCAN_CAPTURE_EN
    , CAPTURE
`endif
  } state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [CHAIN_LEN-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      scan_en     <= 1'b0;
      scan_in     <= 1'b0;
      unload_data <= '0;
      cnt         <= '0;
      shadow      <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          cnt  <= '0;
          if (start) begin
            state   <= SHIFT;
            shadow  <= load_data;
            scan_en <= 1'b1;
            scan_in <= load_data[CHAIN_LEN-1];
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state   <= IDLE;
            scan_en <= 1'b0;
            scan_in <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
          end else begin
            // The last flop's output this cycle is the original bit at chain position LAST-cnt.
            unload_data[LAST - cnt] <= scan_out;
            if (cnt == LAST) begin
              scan_en <= 1'b0;
              scan_in <= 1'b0;
`ifdef C3LIB_SCAN_CAPTURE_EN
              state   <= CAPTURE;
`else
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              cnt     <= cnt + CNT_W'(1);
              scan_in <= shadow[CHAIN_LEN-2];
              shadow  <= {shadow[CHAIN_LEN-2:0], 1'b0};
            end
          end
        end
`ifdef C3LIB_SCAN_CAPTURE_EN
        CAPTURE: begin
          busy <= 1'b0;
          cnt  <= '0;
          if (abort) begin
            state <= IDLE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
`endif
        DONE: begin
          done  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c3lib_scan_shift_ctrl.sv
// tb/tb_c3lib_scan_shift_ctrl.sv - self-checking bench for c3lib_scan_shift_ctrl with a modelled 8-flop chain
`timescale 1ns/1ps
module tb_c3lib_scan_shift_ctrl;
  localparam int N = 8;
`ifdef C3LIB_SCAN_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  localparam int LAT = N + 1 + int'(CAP);
  localparam logic [N-1:0] DATA_IN = 8'h5A;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] load_data = '0;
  logic         busy, done, scan_en, scan_in, scan_out;
  logic [N-1:0] unload_data;

  logic [N-1:0] chain = '0;
  logic         preload_en = 1'b0;
  logic [N-1:0] preload_val = '0;

  int           total = 0;
  int           bad = 0;
  logic [N-1:0] m_chain = '0;
  logic [N-1:0] m_unload = '0;

  typedef struct {
    logic [N-1:0] pre;
    logic [N-1:0] load;
    logic [N-1:0] exp_unload;
    logic [N-1:0] exp_sin;
    logic [N-1:0] exp_chain;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  c3lib_scan_shift_ctrl #(.CHAIN_LEN(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .load_data(load_data),
    .busy(busy), .done(done), .unload_data(unload_data),
    .scan_en(scan_en), .scan_in(scan_in), .scan_out(scan_out)
  );

  // Attached chain: shifts under scan_en, samples functional data in a busy non-shift cycle.
  assign scan_out = chain[N-1];
  always @(posedge clk) begin
    if (preload_en)         chain <= preload_val;
    else if (scan_en)       chain <= {chain[N-2:0], scan_in};
    else if (busy)          chain <= DATA_IN;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic preload(input logic [N-1:0] v);
    @(negedge clk); preload_en = 1'b1; preload_val = v;
    @(negedge clk); preload_en = 1'b0;
    m_chain = v;
  endtask

  task automatic do_run(input string tag, input logic [N-1:0] load, input logic [N-1:0] exp_sin,
                        input logic [N-1:0] exp_unload, input logic [N-1:0] exp_chain,
                        input bit abort_at_done);
    int en_cnt, busy_cnt, cap_cnt, done_at;
    logic [N-1:0] sin_seq, got_unload;
    en_cnt = 0; busy_cnt = 0; cap_cnt = 0; done_at = 0;
    sin_seq = '0; got_unload = '0;
    @(negedge clk); start = 1'b1; load_data = load;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0; load_data = N'($urandom);
    for (int c = 1; c <= LAT + 3; c++) begin
      @(negedge clk);
      if (c == LAT) abort = abort_at_done;
      if (c == LAT + 1) abort = 1'b0;
      if (scan_en) begin en_cnt++; sin_seq = {sin_seq[N-2:0], scan_in}; end
      if (busy) busy_cnt++;
      if (busy && !scan_en) cap_cnt++;
      if (done && done_at == 0) begin done_at = c; got_unload = unload_data; end
    end
    check({tag, " scan_en cycles"}, en_cnt, N);
    check({tag, " scan_in seq"}, sin_seq, exp_sin);
    check({tag, " done latency"}, done_at, LAT);
    check({tag, " busy cycles"}, busy_cnt, LAT - 1);
    check({tag, " capture cycles"}, cap_cnt, int'(CAP));
    check({tag, " unload_data"}, got_unload, exp_unload);
    check({tag, " chain"}, chain, exp_chain);
    m_chain = exp_chain;
    m_unload = exp_unload;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int d1, d2, s2, en_cnt;
    logic [N-1:0] u1, u2, exp_part;
    bit seen_done;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'b00111100, CAP ? DATA_IN : 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, CAP ? DATA_IN : 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, CAP ? DATA_IN : 8'h00};
    vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E, CAP ? DATA_IN : 8'h7E};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset scan_en", scan_en, 0);
    check("reset scan_in", scan_in, 0);
    check("reset unload_data", unload_data, 0);

    for (int i = 0; i < 4; i++) begin
      preload(vecs[i].pre);
      do_run($sformatf("vec%0d", i), vecs[i].load, vecs[i].exp_sin, vecs[i].exp_unload,
             vecs[i].exp_chain, i == 1);
    end

    // start held high across two sequences
    preload(8'h00);
    d1 = 0; d2 = 0; s2 = 0; en_cnt = 0; u1 = '0; u2 = '0;
    @(negedge clk); start = 1'b1; load_data = 8'h01;
    @(posedge clk); #1 load_data = 8'hFF;
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      @(negedge clk);
      if (scan_en) begin en_cnt++; if (d1 != 0 && s2 == 0) s2 = c; end
      if (done) begin
        if (d1 == 0) begin d1 = c; u1 = unload_data; end
        else if (d2 == 0) begin d2 = c; u2 = unload_data; end
      end
      if (c == LAT + 2) start = 1'b0;
    end
    start = 1'b0;
    check("b2b first done", d1, LAT);
    check("b2b second shift start", s2, LAT + 2);
    check("b2b second done", d2, 2 * LAT + 1);
    check("b2b first unload", u1, 8'h00);
    check("b2b second unload", u2, CAP ? DATA_IN : 8'h01);
    check("b2b scan_en cycles", en_cnt, 2 * N);
    m_unload = CAP ? DATA_IN : 8'h01;
    m_chain = CAP ? DATA_IN : 8'hFF;

    // abort during SHIFT cycle k=3
    preload(8'hA5);
    exp_part = (8'hA5 & 8'hE0) | (m_unload & 8'h1F);
    @(negedge clk); start = 1'b1; load_data = 8'h3C;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort scan_en", scan_en, 0);
    check("abort busy", busy, 0);
    check("abort partial unload", unload_data, exp_part);
    seen_done = 1'b0;
    repeat (LAT) begin @(negedge clk); if (done || scan_en) seen_done = 1'b1; end
    check("abort no done", seen_done, 0);
    m_unload = exp_part;

    // asynchronous reset at SHIFT cycle k=5
    preload(8'h96);
    @(negedge clk); start = 1'b1; load_data = 8'h69;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(negedge clk);
    check("pre-reset scan_en", scan_en, 1);
    rst_n = 1'b0;
    #1;
    check("async reset scan_en", scan_en, 0);
    check("async reset busy", busy, 0);
    check("async reset unload", unload_data, 0);
    @(negedge clk); rst_n = 1'b1;
    preload(8'h0F);
    do_run("post-reset", 8'hC3, 8'hC3, 8'h0F, CAP ? DATA_IN : 8'hC3, 1'b0);

    // random loads, idle gaps with stray abort, abort alongside start
    for (int r = 0; r < 20; r++) begin
      logic [N-1:0] ld;
      ld = N'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk); abort = 1'($urandom);
      end
      abort = 1'($urandom);
      do_run($sformatf("rand%0d", r), ld, ld, m_chain, CAP ? DATA_IN : ld, 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c3lib_scan_shift_ctrl.md
Name: c3lib_scan_shift_ctrl

Overview:
- Scan-load/unload sequencer directly upstream of a chain of c3lib scan-reset flops.
- Drives the chain's shared scan_en and its first scan_in; consumes the last flop's data_out as scan_out.
- Serially loads a parallel word into the chain and simultaneously unloads the prior chain contents.
- Used for cell-hardened config/debug chains in the c3lib primitive layer.

Parameters:
- CHAIN_LEN, 8, number of scan flops in the attached chain; legal range 2..1024.
- CNT_W, $clog2(CHAIN_LEN), shift counter width; derived, not overridden.

Ports:
- clk  input  1  chain clock; same clock as the scan flops.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- abort  input  1  synchronous abort of a sequence in progress.
- load_data  input  CHAIN_LEN  word to load; element j of the chain ends holding load_data[j]; sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; unload_data valid from this cycle.
- unload_data  output  CHAIN_LEN  prior chain contents; bit j = chain element j before the load.
- scan_en  output  1  to every flop's scan_en.
- scan_in  output  1  to chain element 0 scan_in.
- scan_out  input  1  data_out of chain element CHAIN_LEN-1.

Behaviour:
- Clocking: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, busy=0, done=0, scan_en=0, scan_in=0, unload_data=0, counter=0, shadow load register=0.
- All outputs are registered. The chain flop ahead of element 0 is this block's scan_in register.
- States: IDLE, SHIFT, CAPTURE (macro only), DONE.
- IDLE:
  - start=1 captures load_data into the shadow register and sets counter=0.
  - Next state SHIFT: scan_en=1, scan_in=load_data[CHAIN_LEN-1], busy=1.
- SHIFT, cycle k (k=0..CHAIN_LEN-1):
  - scan_en=1 and scan_in=shadow[CHAIN_LEN-1-k] (MSB first).
  - At the posedge ending cycle k: unload_data[CHAIN_LEN-1-k] <= scan_out.
  - Counter increments; when counter==CHAIN_LEN-1 the next state is CAPTURE (macro) or DONE.
- Latency: exactly CHAIN_LEN cycles with scan_en=1; start to done = CHAIN_LEN+1 cycles (CHAIN_LEN+2 with the macro).
- DONE:
  - One cycle: done=1, busy=0, scan_en=0, scan_in=0; next state IDLE.
  - start in the DONE cycle is ignored.
- start while busy is ignored and does not queue.
- abort:
  - Valid in SHIFT or CAPTURE; next cycle state=IDLE, scan_en=0, busy=0.
  - No done pulse; unload_data keeps its partial contents; chain contents are undefined.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start wins (abort has no effect).
- Counter never wraps; it is cleared on entry to IDLE.
- rst_n asserted mid-sequence: all state returns to reset values asynchronously; scan_en drops immediately.

Optional Feature:
- Macro: C3LIB_SCAN_CAPTURE_EN.
- Defined:
  - After the last SHIFT cycle, one CAPTURE cycle with scan_en=0 and busy=1, so the chain flops sample functional data_in.
  - Then DONE. Start to done = CHAIN_LEN+2 cycles.
  - abort during CAPTURE behaves as in SHIFT.
- Undefined: no CAPTURE state; SHIFT goes directly to DONE.

Test Plan:
- Reset: CHAIN_LEN=8, hold rst_n=0 for 3 cycles, then release -> all outputs 0, state IDLE, scan_en=0.
- Load/unload, macro off:
  - Stimulus: model chain preloaded 8'hA5, start with load_data=8'h3C.
  - Response: scan_en=1 for exactly 8 cycles; scan_in sequence 0,0,1,1,1,1,0,0; done pulses 9 cycles after start; unload_data=8'hA5; model chain=8'h3C.
- Back-to-back:
  - Stimulus: start held high continuously with load_data 8'h01 then 8'hFF.
  - Response: second sequence begins only in the IDLE cycle after DONE; unload_data of the second run=8'h01.
- Abort:
  - Stimulus: abort at SHIFT cycle k=3.
  - Response: next cycle scan_en=0, busy=0; no done; unload_data[7:5] updated, other bits unchanged.
- Async reset mid-shift: rst_n low at k=5 -> scan_en=0 immediately (before the next clk edge); a subsequent start runs a full 8-cycle sequence.
- Macro on:
  - Stimulus: C3LIB_SCAN_CAPTURE_EN defined, load_data=8'h3C.
  - Response: exactly one scan_en=0, busy=1 cycle after the 8 shift cycles; model chain captures its data_in value; done 10 cycles after start.
